// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetches 32-bit instruction words from a fixed one-cycle-latency instruction
// memory and presents them, in program order, to the decoder through a 2-entry
// {pc, data} FIFO. Branch/jump redirects flush the FIFO and drop any read
// still in flight.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   adds output fetch_misaligned and a HALT state entered on a redirect whose
//   target is not word aligned. Without the macro the target's low two bits
//   are ignored (forced to zero) and there is no HALT state.
//
// Ports:
//   clk              in   1   single clock, rising edge
//   reset            in   1   asynchronous, active-high reset
//   imem_addr        out  32  fetch address (meaningful while imem_rd=1)
//   imem_rd          out  1   read issue strobe
//   imem_data        in   32  read data, valid the cycle after issue
//   inst_valid       out  1   head instruction available
//   inst_data        out  32  head instruction word
//   inst_pc          out  32  address of head instruction
//   inst_ready       in   1   decoder accepts the head this cycle
//   redirect_valid   in   1   redirect request
//   redirect_pc      in   32  redirect target
//   fetch_misaligned out  1   (macro only) misaligned redirect trap flag
//   dbg_state_o      out  2   current FSM state (0=BOOT, 1=RUN, 2=HALT)
//
// Handshake: the head moves on a cycle where inst_valid=1 and inst_ready=1
// at the rising edge; while inst_valid=1 and inst_ready=0 the head
// (inst_data, inst_pc) is held stable. A redirect in the same cycle wins and
// the head is discarded together with the rest of the FIFO.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic [1:0]  dbg_state_o
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  // FIFO slot 0 is always the head; slot 1 is only meaningful when count=2.
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic [1:0]  count_q, count_d;
  logic        in_flight_q, in_flight_d;
  logic [31:0] flight_pc_q, flight_pc_d;
  logic        squash_q, squash_d;

  logic [31:0] redir_target;
  logic        pop_req;
  logic        fifo_pop;
  logic        fifo_write;
  logic        squash_now;
  logic        room;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  logic        redir_misaligned;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_target     = redirect_pc;
  assign fetch_misaligned = mis_q;
`else
  // Instructions are word aligned; the low bits of a target carry no meaning.
  logic unused_redir_lsbs;
  assign unused_redir_lsbs = ^redirect_pc[1:0];
  assign redir_target      = {redirect_pc[31:2], 2'b00};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_BOOT;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // Only a redirect leaves HALT, and only an aligned one.
    if (redirect_valid) state_d = redir_misaligned ? ST_HALT : ST_RUN;
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Issue only if the word returning next cycle is guaranteed a slot even
  // when the decoder stalls: entries held + word already in flight - entry
  // leaving now must stay below the FIFO depth.
  assign pop_req = inst_valid & inst_ready;
  assign room    = (({1'b0, count_q} + {2'b00, in_flight_q}) - {2'b00, pop_req}) < 3'd2;

  always_comb begin
    imem_rd = 1'b0;
    if (state_q == ST_RUN && !redirect_valid && room) imem_rd = 1'b1;
  end

  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = (count_q != 2'd0);
  assign inst_data   = data0_q;
  assign inst_pc     = pc0_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  // A word returning in a redirect cycle belongs to the old path.
  assign squash_now = redirect_valid & in_flight_q;
  assign fifo_write = in_flight_q & ~squash_now & ~squash_q;
  assign fifo_pop   = pop_req & ~redirect_valid;

  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    count_d = count_q;
    case ({fifo_pop, fifo_write})
      2'b10: begin
        pc0_d   = pc1_q;
        data0_d = data1_q;
        count_d = count_q - 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd0) begin
          pc0_d   = flight_pc_q;
          data0_d = imem_data;
        end else begin
          pc1_d   = flight_pc_q;
          data1_d = imem_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        // Pop and write together: the older entry shifts into the head first
        // so program order is kept.
        if (count_q == 2'd2) begin
          pc0_d   = pc1_q;
          data0_d = data1_q;
          pc1_d   = flight_pc_q;
          data1_d = imem_data;
        end else begin
          pc0_d   = flight_pc_q;
          data0_d = imem_data;
        end
      end
      default: ;
    endcase
    if (redirect_valid) count_d = 2'd0;
  end

  always_comb begin
    in_flight_d = imem_rd;
    flight_pc_d = imem_rd ? fetch_pc_q : flight_pc_q;
    squash_d    = squash_now;
    fetch_pc_d  = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redir_target;
    else if (imem_rd)   fetch_pc_d = fetch_pc_q + 32'd4;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_comb begin
    mis_d = mis_q;
    if (redirect_valid) mis_d = redir_misaligned;
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      pc0_q       <= 32'h0;
      pc1_q       <= 32'h0;
      data0_q     <= 32'h0;
      data1_q     <= 32'h0;
      count_q     <= 2'd0;
      in_flight_q <= 1'b0;
      flight_pc_q <= 32'h0;
      squash_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc0_q       <= pc0_d;
      pc1_q       <= pc1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      flight_pc_q <= flight_pc_d;
      squash_q    <= squash_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed vector table for the fetch timeline, redirects, wrap and
// misaligned targets, a hand-written asynchronous reset with a full FIFO,
// and a randomized run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [1:0]  dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .dbg_state_o    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Instruction memory: content is a bijective function of the address, and
  // the bus carries junk whenever no read was issued the cycle before.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic        rd_seen = 1'b0;
  logic [31:0] addr_seen = 32'h0;

  always @(negedge clk) begin
    rd_seen   = imem_rd;
    addr_seen = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_data = rd_seen ? mem_word(addr_seen) : $urandom;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          e_rd;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc,
                     input bit e_rd, input logic [31:0] e_addr,
                     input bit e_valid, input logic [31:0] e_pc, input bit e_mis);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  task automatic fill_table();
    // Startup with decoder always ready: issue 0,4,8,C; first valid in cycle 3.
    add(1, 1, 0, 0, 0, RESET_PC, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,      0, 0, 0);           // BOOT
    add(0, 1, 0, 0, 1, 32'h0,  0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h4,  0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h8,  1, 32'h0, 0);
    add(0, 1, 0, 0, 1, 32'hC,  1, 32'h4, 0);
    add(0, 1, 0, 0, 1, 32'h10, 1, 32'h8, 0);
    // Stall from cycle 3: two issues, head held at 0, then drain and resume at 8.
    add(1, 1, 0, 0, 0, RESET_PC, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,      0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h0,  0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h4,  0, 0, 0);
    add(0, 0, 0, 0, 0, 0,      1, 32'h0, 0);
    add(0, 0, 0, 0, 0, 0,      1, 32'h0, 0);
    add(0, 0, 0, 0, 0, 0,      1, 32'h0, 0);
    add(0, 1, 0, 0, 1, 32'h8,  1, 32'h0, 0);
    add(0, 1, 0, 0, 1, 32'hC,  1, 32'h4, 0);
    add(0, 1, 0, 0, 1, 32'h10, 1, 32'h8, 0);
    // Redirect to 0x40 with a read in flight, one entry queued and a pop offered.
    add(0, 1, 1, 32'h40, 0, 0, 1, 32'hC, 0);
    add(0, 1, 0, 0, 1, 32'h40, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h44, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h48, 1, 32'h40, 0);
    // Back-to-back redirects: the last one wins.
    add(0, 1, 1, 32'h100, 0, 0, 1, 32'h44, 0);
    add(0, 1, 1, 32'h200, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h200, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h204, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h208, 1, 32'h200, 0);
    // Address wrap.
    add(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 1, 32'h204, 0);
    add(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFF8, 0);
    add(0, 1, 0, 0, 1, 32'h4, 1, 32'hFFFF_FFFC, 0);
    add(0, 1, 0, 0, 1, 32'h8, 1, 32'h0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned target traps and halts; an aligned redirect recovers.
    add(0, 1, 1, 32'h42, 0, 0, 1, 32'h4, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 32'h80, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 32'h80, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h84, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h88, 1, 32'h80, 0);
`else
    // Misaligned target: low bits ignored.
    add(0, 1, 1, 32'h302, 0, 0, 1, 32'h4, 0);
    add(0, 1, 0, 0, 1, 32'h300, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h304, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h308, 1, 32'h300, 0);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: program-order queue of {pc, data}, one outstanding read.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_boot, m_halt, m_mis, m_infl;
  logic [31:0] m_infl_pc;

  task automatic model_clear();
    mq.delete();
    m_pc   = RESET_PC;
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_mis  = 1'b0;
    m_infl = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd"},    imem_rd,    0);
    chk({tag, "_addr"},  imem_addr,  RESET_PC);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_pc"},    inst_pc,    0);
    chk({tag, "_data"},  inst_data,  0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, "_mis"},   fetch_misaligned, 0);
`endif
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic model_reset();
    reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    check_reset_outputs("mreset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic model_cycle(input bit r, input bit rv, input logic [31:0] rp);
    bit pop, e_rd;
    inst_ready = r; redirect_valid = rv; redirect_pc = rp;
    @(negedge clk);
    pop  = (mq.size() > 0) && r;
    e_rd = !m_boot && !m_halt && !rv && ((mq.size() + int'(m_infl) - int'(pop)) < 2);
    chk("m_rd", imem_rd, e_rd);
    if (e_rd) chk("m_addr", imem_addr, m_pc);
    chk("m_valid", inst_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_pc",   inst_pc,   mq[0].pc);
      chk("m_data", inst_data, mq[0].data);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("m_mis", fetch_misaligned, m_mis);
`endif
    if (rv) begin
      mq.delete();
      m_infl = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_mis  = (rp[1:0] != 2'b00);
      m_halt = m_mis;
      m_pc   = rp;
`else
      m_pc   = rp & 32'hFFFF_FFFC;
`endif
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_infl_pc, data: mem_word(m_infl_pc)});
      m_infl = e_rd;
      if (e_rd) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    m_boot = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rpc;
    fill_table();
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      reset          = tbl[i].rst;
      inst_ready     = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d_rd", i), imem_rd, tbl[i].e_rd);
      if (tbl[i].e_rd || tbl[i].rst) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), inst_valid, tbl[i].e_valid);
      if (tbl[i].rst) begin
        chk($sformatf("v%0d_pc", i),   inst_pc,   0);
        chk($sformatf("v%0d_data", i), inst_data, 0);
      end else if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),   inst_pc,   tbl[i].e_pc);
        chk($sformatf("v%0d_data", i), inst_data, mem_word(tbl[i].e_pc));
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      chk($sformatf("v%0d_mis", i), fetch_misaligned, tbl[i].e_mis);
`endif
      @(posedge clk); #1;
    end

    // Randomized run against the model.
    model_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF0;
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      model_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rpc);
    end

    // Asynchronous reset in the middle of a cycle with a full FIFO.
    model_cycle(1'b1, 1'b1, 32'h1000);
    for (int i = 0; i < 5; i++) model_cycle(1'b0, 1'b0, 32'h0);
    chk("full_valid_before_reset", inst_valid, 1);
    chk("full_pc_before_reset", inst_pc, 32'h1000);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    @(posedge clk); #1;
    check_reset_outputs("async_held");
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) model_cycle(1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr  output  32  word address presented to instruction_memory.
REQ-005 SHALL have port imem_rd  output  1  read issue strobe; imem_addr is valid when it is 1.
REQ-006 SHALL have port imem_data  input  32  read data, valid exactly one cycle after the issue cycle.
REQ-007 SHALL have port inst_valid  output  1  head instruction available to the decoder.
REQ-008 SHALL have port inst_data  output  32  head instruction word.
REQ-009 SHALL have port inst_pc  output  32  address of the head instruction.
REQ-010 SHALL have port inst_ready  input  1  decoder accepts the head this cycle.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-012 SHALL have port redirect_pc  input  32  redirect target.

Function
REQ-013 SHALL hold fetch_pc, a 2-entry FIFO of {pc, data}, an in-flight flag and a squash flag.
REQ-014 SHALL implement FSM states: BOOT, which lasts one cycle after reset release with no issue; RUN; and HALT, which exists only with the macro.
REQ-015 SHALL in RUN issue (imem_rd=1, imem_addr=fetch_pc) when occupancy + in_flight - pop < 2, where pop = inst_valid & inst_ready.
REQ-016 SHALL on issue advance fetch_pc by 4, modulo 2^32, so that 32'hFFFFFFFC wraps to 32'h0.
REQ-017 SHALL write {issued pc, imem_data} into the FIFO tail at the edge ending the cycle after issue, unless squashed.
REQ-018 SHALL drive inst_valid = FIFO non-empty, with inst_data and inst_pc taken from the head; total latency is issue in cycle N, visible in cycle N+2.
REQ-019 SHALL sustain one instruction per cycle when inst_ready is held at 1.
REQ-020 SHALL on pop advance the head; a simultaneous pop and write on a full or 1-entry FIFO SHALL preserve order.
REQ-021 SHALL hold inst_data and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-022 SHALL on redirect_valid=1 flush the FIFO, set squash if a read is in flight, load fetch_pc=redirect_pc, and suppress issue in that cycle.
REQ-023 SHALL resume issue the next cycle at redirect_pc.
REQ-024 SHALL give redirect priority over a same-cycle pop; the pop is discarded and inst_valid falls to 0 the next cycle.
REQ-025 SHALL accept back-to-back redirects, with the last one winning.
REQ-026 SHALL never write the FIFO beyond 2 entries and never pop it when empty.

Reset
REQ-027 SHALL on reset assertion, at any time including mid-fetch, immediately force: imem_rd=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, FIFO empty, in_flight=0, squash=0, fetch_pc=RESET_PC, state=BOOT.
REQ-028 SHALL discard any imem_data returning in the first cycle after reset release.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_TRAP_EN defined, add output fetch_misaligned (1 bit, reset 0).
REQ-030 SHALL, with the macro defined, set fetch_misaligned on a redirect whose redirect_pc[1:0]!=0, flush the FIFO, and enter HALT with no further issue.
REQ-031 SHALL, with the macro defined, leave HALT and clear fetch_misaligned only on an aligned redirect, which returns the FSM to RUN, or on reset.
REQ-032 SHALL, without the macro, omit the port and the HALT state and force redirect_pc[1:0] to 0.

Verification
REQ-033 Reset release with RESET_PC=0 and inst_ready=1 -> imem_addr 0, 4, 8, 0xC on cycles 1-4; inst_valid first rises in cycle 3 with inst_pc=0; thereafter one instruction per cycle in order.
REQ-034 inst_ready=0 from cycle 3 -> at most 2 issues land in the FIFO, imem_rd=0 afterwards, and the head stays at pc 0; releasing inst_ready drains pcs 0 and 4, then issue resumes at 8.
REQ-035 Redirect to 0x40 with a read in flight and one entry queued -> the in-flight data is dropped, inst_valid=0 the next cycle, and the next issue is at 0x40; the next valid inst_pc=0x40.
REQ-036 fetch_pc=0xFFFFFFFC -> issues 0xFFFFFFFC then 0x0.
REQ-037 Reset asserted mid-stream with a full FIFO -> all outputs go to reset values asynchronously, and the first post-release issue is at RESET_PC.
REQ-038 With the macro defined, redirect to 0x42 -> fetch_misaligned=1 and imem_rd held 0; a following redirect to 0x80 -> fetch_misaligned=0 and issue resumes at 0x80.
